vga_bar_display: RTL and testbench

- Parametrised VGA timing generator and bar renderer; next generation of the single-mode 640x480 bar display.
- Produces hsync/vsync from a full porch/sync/back-porch timing model with an internal pixel-clock divider.
- Renders CELLS framebuffer bits as equal-width columns inside a horizontal band, with configurable colours.
- Framebuffer is latched once per frame so a frame never tears. Sits between game logic (framebuffer source) and the board VGA pins.

---
 rtl/vga_bar_pkg.sv | 41 ++++
 rtl/vga_bar_timing.sv | 109 ++++++++++
 rtl/vga_bar_display.sv | 184 ++++++++++++++++++
 tb/tb_vga_bar_display.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/vga_bar_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vga_bar_pkg
// Purpose  : Shared constants and helpers for the VGA bar display.
//            Holds the default 640x480@60 timing, the sync-polarity encoding,
//            the default layout values and a helper that sums a timing axis.
// Ports    : none (package)
// Revision : 1.0 - initial parametrised release
// ============================================================================
package vga_bar_pkg;

  // Sync polarity encoding: the value is the level driven while sync is active.
  localparam int SYNC_ACTIVE_LOW  = 0;
  localparam int SYNC_ACTIVE_HIGH = 1;

  // Default 640x480@60 timing (25 MHz pixel clock from a 50 MHz system clock).
  localparam int DEF_CLK_DIV  = 2;
  localparam int DEF_H_VIS    = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_VIS    = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_SYNC_POL = SYNC_ACTIVE_LOW;

  // Default bar layout.
  localparam int DEF_CELLS   = 8;
  localparam int DEF_BAR_Y0  = 211;
  localparam int DEF_BAR_Y1  = 270;
  localparam int DEF_COLOR_W = 1;

  // Total length of one timing axis (H_TOTAL or V_TOTAL).
  function automatic int vga_total(input int vis, input int fp,
                                   input int sync, input int bp);
    return vis + fp + sync + bp;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_bar_timing.sv
`default_nettype none
// ============================================================================
// Module   : vga_bar_timing
// Purpose  : Pixel-clock divider, horizontal/vertical counters and registered
//            sync generation for a porch/sync/back-porch VGA timing model.
// Ports    : clock, reset   - system clock, synchronous active-high reset
//            pix_en         - one-clock pixel tick (constant 1 when CLK_DIV=1)
//            h_cnt, v_cnt   - current pixel position (advance on pix_en)
//            visible        - h_cnt/v_cnt inside the active area
//            hsync, vsync   - registered sync, one tick behind the counters
// Revision : 1.0 - initial parametrised release
// ============================================================================
module vga_bar_timing
  import vga_bar_pkg::*;
#(
  parameter int CLK_DIV  = DEF_CLK_DIV,
  parameter int H_VIS    = DEF_H_VIS,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_VIS    = DEF_V_VIS,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int SYNC_POL = DEF_SYNC_POL,
  parameter int H_W      = $clog2(vga_total(H_VIS, H_FP, H_SYNC, H_BP) + 1),
  parameter int V_W      = $clog2(vga_total(V_VIS, V_FP, V_SYNC, V_BP) + 1)
) (
  input  logic           clock,
  input  logic           reset,
  output logic           pix_en,
  output logic [H_W-1:0] h_cnt,
  output logic [V_W-1:0] v_cnt,
  output logic           visible,
  output logic           hsync,
  output logic           vsync
);

  localparam int H_TOTAL = vga_total(H_VIS, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = vga_total(V_VIS, V_FP, V_SYNC, V_BP);

  localparam logic [H_W-1:0] H_LAST   = H_W'(H_TOTAL - 1);
  localparam logic [H_W-1:0] H_VIS_C  = H_W'(H_VIS);
  localparam logic [H_W-1:0] HS_START = H_W'(H_VIS + H_FP);
  localparam logic [H_W-1:0] HS_END   = H_W'(H_VIS + H_FP + H_SYNC);
  localparam logic [V_W-1:0] V_LAST   = V_W'(V_TOTAL - 1);
  localparam logic [V_W-1:0] V_VIS_C  = V_W'(V_VIS);
  localparam logic [V_W-1:0] VS_START = V_W'(V_VIS + V_FP);
  localparam logic [V_W-1:0] VS_END   = V_W'(V_VIS + V_FP + V_SYNC);

  localparam logic SYNC_ON = (SYNC_POL != 0);

  // Pixel tick: fires on the last system clock of each pixel period.
  generate
    if (CLK_DIV > 1) begin : g_div
      localparam int DIV_W = $clog2(CLK_DIV);
      localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
      logic [DIV_W-1:0] div_cnt;

      always_ff @(posedge clock) begin
        if (reset) begin
          div_cnt <= '0;
        end else if (div_cnt == DIV_LAST) begin
          div_cnt <= '0;
        end else begin
          div_cnt <= div_cnt + DIV_W'(1);
        end
      end

      assign pix_en = (div_cnt == DIV_LAST);
    end else begin : g_no_div
      assign pix_en = 1'b1;
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_en) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + V_W'(1);
      end else begin
        h_cnt <= h_cnt + H_W'(1);
      end
    end
  end

  logic h_in_sync;
  logic v_in_sync;

  assign h_in_sync = (h_cnt >= HS_START) && (h_cnt < HS_END);
  assign v_in_sync = (v_cnt >= VS_START) && (v_cnt < VS_END);
  assign visible   = (h_cnt < H_VIS_C) && (v_cnt < V_VIS_C);

  // Registered so sync lines up with the registered colour in the top level.
  always_ff @(posedge clock) begin
    if (reset) begin
      hsync <= ~SYNC_ON;
      vsync <= ~SYNC_ON;
    end else if (pix_en) begin
      hsync <= h_in_sync ? SYNC_ON : ~SYNC_ON;
      vsync <= v_in_sync ? SYNC_ON : ~SYNC_ON;
    end
  end

endmodule
`default_nettype wire

// File: rtl/vga_bar_display.sv
`default_nettype none
// ============================================================================
// Module   : vga_bar_display
// Purpose  : VGA timing plus bar renderer. CELLS framebuffer bits are drawn
//            as equal-width columns inside the band BAR_Y0 <= y < BAR_Y1.
//            The framebuffer is latched once per frame so a frame never tears.
// Ports    : clock, reset          - system clock, sync active-high reset
//            framebuffer[CELLS]    - cell states, bit 0 = leftmost column
//            fg_rgb, bg_rgb        - lit / unlit colour {r,g,b}
//            vga_hsync, vga_vsync  - sync outputs (active level SYNC_POL)
//            vga_r, vga_g, vga_b   - colour outputs, 0 during blanking
//            frame_start           - one-clock pulse as counters wrap to (0,0)
// Options  : VGA_BAR_BORDER_EN     - when defined, the outermost visible
//                                    rows/columns are drawn in fg_rgb
// Revision : 1.0 - initial parametrised release
// ============================================================================
module vga_bar_display
  import vga_bar_pkg::*;
#(
  parameter int CLK_DIV  = DEF_CLK_DIV,
  parameter int H_VIS    = DEF_H_VIS,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_VIS    = DEF_V_VIS,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int SYNC_POL = DEF_SYNC_POL,
  parameter int CELLS    = DEF_CELLS,
  parameter int BAR_Y0   = DEF_BAR_Y0,
  parameter int BAR_Y1   = DEF_BAR_Y1,
  parameter int COLOR_W  = DEF_COLOR_W
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [CELLS-1:0]     framebuffer,
  input  logic [3*COLOR_W-1:0] fg_rgb,
  input  logic [3*COLOR_W-1:0] bg_rgb,
  output logic                 vga_hsync,
  output logic                 vga_vsync,
  output logic [COLOR_W-1:0]   vga_r,
  output logic [COLOR_W-1:0]   vga_g,
  output logic [COLOR_W-1:0]   vga_b,
  output logic                 frame_start
);

  localparam int H_TOTAL = vga_total(H_VIS, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = vga_total(V_VIS, V_FP, V_SYNC, V_BP);
  localparam int H_W     = $clog2(H_TOTAL + 1);
  localparam int V_W     = $clog2(V_TOTAL + 1);
  localparam int CELL_W  = H_VIS / CELLS;
  localparam int PX_W    = (CELL_W > 1) ? $clog2(CELL_W) : 1;
  localparam int IDX_W   = (CELLS > 1) ? $clog2(CELLS) : 1;

  localparam logic [H_W-1:0]   H_LAST   = H_W'(H_TOTAL - 1);
  localparam logic [V_W-1:0]   V_LAST   = V_W'(V_TOTAL - 1);
  localparam logic [V_W-1:0]   BAND_Y0  = V_W'(BAR_Y0);
  localparam logic [V_W-1:0]   BAND_Y1  = V_W'(BAR_Y1);
  localparam logic [PX_W-1:0]  PX_LAST  = PX_W'(CELL_W - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CELLS - 1);

  logic           pix_en;
  logic [H_W-1:0] h_cnt;
  logic [V_W-1:0] v_cnt;
  logic           visible;

  vga_bar_timing #(
    .CLK_DIV  (CLK_DIV),
    .H_VIS    (H_VIS),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_VIS    (V_VIS),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .SYNC_POL (SYNC_POL),
    .H_W      (H_W),
    .V_W      (V_W)
  ) u_timing (
    .clock   (clock),
    .reset   (reset),
    .pix_en  (pix_en),
    .h_cnt   (h_cnt),
    .v_cnt   (v_cnt),
    .visible (visible),
    .hsync   (vga_hsync),
    .vsync   (vga_vsync)
  );

  logic line_end;
  logic frame_end;

  assign line_end  = pix_en && (h_cnt == H_LAST);
  assign frame_end = line_end && (v_cnt == V_LAST);

  // Column index tracked incrementally so no divide by CELL_W is needed.
  // It parks on the last column through the blanking interval.
  logic [PX_W-1:0]  cell_px;
  logic [IDX_W-1:0] cell_idx;

  always_ff @(posedge clock) begin
    if (reset) begin
      cell_px  <= '0;
      cell_idx <= '0;
    end else if (pix_en) begin
      if (line_end) begin
        cell_px  <= '0;
        cell_idx <= '0;
      end else if (cell_px == PX_LAST) begin
        cell_px <= '0;
        if (cell_idx != IDX_LAST) begin
          cell_idx <= cell_idx + IDX_W'(1);
        end
      end else begin
        cell_px <= cell_px + PX_W'(1);
      end
    end
  end

  // Frame latch: captured on the tick that takes the counters to (0,0), so
  // the whole following frame renders from one framebuffer snapshot.
  logic [CELLS-1:0] fb_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      fb_q        <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= frame_end;
      if (frame_end) begin
        fb_q <= framebuffer;
      end
    end
  end

  logic                 band;
  logic [3*COLOR_W-1:0] pix_rgb;
  logic [3*COLOR_W-1:0] rgb_q;

  assign band = (v_cnt >= BAND_Y0) && (v_cnt < BAND_Y1);

`ifdef VGA_BAR_BORDER_EN
  localparam logic [H_W-1:0] H_VIS_LAST = H_W'(H_VIS - 1);
  localparam logic [V_W-1:0] V_VIS_LAST = V_W'(V_VIS - 1);

  logic border;

  assign border = (h_cnt == '0) || (h_cnt == H_VIS_LAST) ||
                  (v_cnt == '0) || (v_cnt == V_VIS_LAST);

  always_comb begin
    pix_rgb = '0;
    if (visible) begin
      if (border) begin
        pix_rgb = fg_rgb;
      end else if (band) begin
        pix_rgb = fb_q[cell_idx] ? fg_rgb : bg_rgb;
      end
    end
  end
`else
  always_comb begin
    pix_rgb = '0;
    if (visible && band) begin
      pix_rgb = fb_q[cell_idx] ? fg_rgb : bg_rgb;
    end
  end
`endif

  // Same one-tick latency as the sync registers in the timing block.
  always_ff @(posedge clock) begin
    if (reset) begin
      rgb_q <= '0;
    end else if (pix_en) begin
      rgb_q <= pix_rgb;
    end
  end

  assign {vga_r, vga_g, vga_b} = rgb_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_bar_display.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_vga_bar_display
// Purpose  : Directed self-checking bench for vga_bar_display. Two scaled
//            instances share one clock:
//              A: CLK_DIV=2, H 64/4/8/4 (80), V 48/2/2/3 (55), CELLS=8,
//                 band lines 20..27 -> pixel (f,y,x) appears after
//                 system edge 2*(f*4400 + y*80 + x + 1) since reset release.
//              B: CLK_DIV=1, H 8/1/2/1 (12), V 4/1/1/1 (7), CELLS=4,
//                 band lines 1..2 -> pixel (f,y,x) appears after
//                 edge f*84 + y*12 + x + 1 since reset release.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_bar_display;

`ifdef VGA_BAR_BORDER_EN
  localparam bit BORDER = 1'b1;
`else
  localparam bit BORDER = 1'b0;
`endif

  logic clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- instance A ----------------
  logic       reset_a;
  logic [7:0] fb_a;
  logic [2:0] fg_a, bg_a;
  logic       hs_a, vs_a, r_a, g_a, b_a, fs_a;
  logic [2:0] rgb_a;
  assign rgb_a = {r_a, g_a, b_a};

  vga_bar_display #(
    .CLK_DIV(2), .H_VIS(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
    .V_VIS(48), .V_FP(2), .V_SYNC(2), .V_BP(3), .SYNC_POL(0),
    .CELLS(8), .BAR_Y0(20), .BAR_Y1(28), .COLOR_W(1)
  ) dut_a (
    .clock(clock), .reset(reset_a), .framebuffer(fb_a),
    .fg_rgb(fg_a), .bg_rgb(bg_a),
    .vga_hsync(hs_a), .vga_vsync(vs_a),
    .vga_r(r_a), .vga_g(g_a), .vga_b(b_a), .frame_start(fs_a)
  );

  // ---------------- instance B ----------------
  logic       reset_b;
  logic [3:0] fb_b;
  logic [2:0] fg_b, bg_b;
  logic       hs_b, vs_b, r_b, g_b, b_b, fs_b;
  logic [2:0] rgb_b;
  assign rgb_b = {r_b, g_b, b_b};

  vga_bar_display #(
    .CLK_DIV(1), .H_VIS(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_VIS(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_POL(0),
    .CELLS(4), .BAR_Y0(1), .BAR_Y1(3), .COLOR_W(1)
  ) dut_b (
    .clock(clock), .reset(reset_b), .framebuffer(fb_b),
    .fg_rgb(fg_b), .bg_rgb(bg_b),
    .vga_hsync(hs_b), .vga_vsync(vs_b),
    .vga_r(r_b), .vga_g(g_b), .vga_b(b_b), .frame_start(fs_b)
  );

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_bad = 0;
  int edges = 0;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to system edge k after the current reset release, sample #1 later.
  task automatic goto_edge(input int k);
    while (edges < k) begin
      @(posedge clock);
      edges++;
    end
    #1;
  endtask

  function automatic int ea(input int f, input int y, input int x);
    return 2 * (f * 4400 + y * 80 + x + 1);
  endfunction

  function automatic int eb(input int f, input int y, input int x);
    return f * 84 + y * 12 + x + 1;
  endfunction

  initial begin
    reset_a = 1'b1;
    reset_b = 1'b1;
    fb_a = 8'h05; fg_a = 3'd7; bg_a = 3'd2;
    fb_b = 4'b0110; fg_b = 3'd6; bg_b = 3'd1;

    repeat (5) @(posedge clock);
    #1;
    check_eq("a_rst_hsync", hs_a, 1);
    check_eq("a_rst_vsync", vs_a, 1);
    check_eq("a_rst_rgb",   rgb_a, 0);
    check_eq("a_rst_fs",    fs_a, 0);
    reset_a = 1'b0;
    edges = 0;

    // hsync: active for h 68..75, seen one tick later.
    goto_edge(137); check_eq("a_hs_pre_fall", hs_a, 1);
    goto_edge(138); check_eq("a_hs_fall",     hs_a, 0);
    goto_edge(153); check_eq("a_hs_low_end",  hs_a, 0);
    goto_edge(154); check_eq("a_hs_rise",     hs_a, 1);
    goto_edge(297); check_eq("a_hs_l1_pre",   hs_a, 1);
    goto_edge(298); check_eq("a_hs_l1_fall",  hs_a, 0);

    // Frame 0 renders from the reset snapshot (all zero) -> band is bg.
    goto_edge(ea(0, 24, 8)); check_eq("a_f0_band_bg", rgb_a, 2);

    // vsync: active for lines 50..51.
    goto_edge(8001);  check_eq("a_vs_pre_fall", vs_a, 1);
    goto_edge(8002);  check_eq("a_vs_fall",     vs_a, 0);
    goto_edge(8321);  check_eq("a_vs_low_end",  vs_a, 0);
    goto_edge(8322);  check_eq("a_vs_rise",     vs_a, 1);

    goto_edge(8799);  check_eq("a_fs_pre",  fs_a, 0);
    goto_edge(8800);  check_eq("a_fs_0",    fs_a, 1);
    goto_edge(8801);  check_eq("a_fs_post", fs_a, 0);

    // Frame 1: fb=0000_0101, fg=7, bg=2, columns 8 pixels wide.
    goto_edge(ea(1, 0, 10));  check_eq("a_f1_top_row", rgb_a, BORDER ? 32'd7 : 32'd0);
    goto_edge(ea(1, 19, 5));  check_eq("a_f1_y19",     rgb_a, 0);
    goto_edge(ea(1, 24, 0));  check_eq("a_f1_x0",      rgb_a, 7);
    goto_edge(ea(1, 24, 7));  check_eq("a_f1_x7",      rgb_a, 7);
    goto_edge(ea(1, 24, 8));  check_eq("a_f1_x8",      rgb_a, 2);
    goto_edge(ea(1, 24, 16)); check_eq("a_f1_x16",     rgb_a, 7);
    goto_edge(ea(1, 24, 23)); check_eq("a_f1_x23",     rgb_a, 7);
    goto_edge(ea(1, 24, 24)); check_eq("a_f1_x24",     rgb_a, 2);
    goto_edge(ea(1, 24, 63)); check_eq("a_f1_x63",     rgb_a, BORDER ? 32'd7 : 32'd2);
    goto_edge(ea(1, 24, 64)); check_eq("a_f1_blank64", rgb_a, 0);
    goto_edge(ea(1, 24, 79)); check_eq("a_f1_blank79", rgb_a, 0);
    goto_edge(ea(1, 28, 5));  check_eq("a_f1_y28",     rgb_a, 0);

    goto_edge(ea(1, 30, 0));
    fb_a = 8'h00;
    fg_a = 3'd5;

    goto_edge(16801); check_eq("a_vs_f1_pre",  vs_a, 1);
    goto_edge(16802); check_eq("a_vs_f1_fall", vs_a, 0);
    goto_edge(17599); check_eq("a_fs1_pre",    fs_a, 0);
    goto_edge(17600); check_eq("a_fs_1",       fs_a, 1);

    // Frame 2 latched 0x00; change to 0xFF mid-frame, must not show.
    goto_edge(ea(2, 10, 5)); check_eq("a_f2_y10", rgb_a, 0);
    goto_edge(ea(2, 22, 0));
    fb_a = 8'hFF;
    goto_edge(ea(2, 24, 8));  check_eq("a_f2_tear_x8",  rgb_a, 2);
    goto_edge(ea(2, 24, 40)); check_eq("a_f2_tear_x40", rgb_a, 2);
    goto_edge(ea(2, 24, 70)); check_eq("a_f2_blank70",  rgb_a, 0);

    // Frame 3 picks up 0xFF.
    goto_edge(ea(3, 24, 8));  check_eq("a_f3_x8",  rgb_a, 5);
    goto_edge(ea(3, 24, 40)); check_eq("a_f3_x40", rgb_a, 5);
    goto_edge(ea(3, 24, 63)); check_eq("a_f3_x63", rgb_a, 5);

    // ---------------- instance B ----------------
    check_eq("b_rst_hsync", hs_b, 1);
    check_eq("b_rst_vsync", vs_b, 1);
    check_eq("b_rst_rgb",   rgb_b, 0);
    check_eq("b_rst_fs",    fs_b, 0);
    reset_b = 1'b0;
    edges = 0;

    goto_edge(9);  check_eq("b_hs_pre",     hs_b, 1);
    goto_edge(10); check_eq("b_hs_fall",    hs_b, 0);
    goto_edge(11); check_eq("b_hs_low",     hs_b, 0);
    goto_edge(12); check_eq("b_hs_rise",    hs_b, 1);
    goto_edge(21); check_eq("b_hs_l1_pre",  hs_b, 1);
    goto_edge(22); check_eq("b_hs_l1_fall", hs_b, 0);
    goto_edge(60); check_eq("b_vs_pre",     vs_b, 1);
    goto_edge(61); check_eq("b_vs_fall",    vs_b, 0);
    goto_edge(72); check_eq("b_vs_low",     vs_b, 0);
    goto_edge(73); check_eq("b_vs_rise",    vs_b, 1);
    goto_edge(83); check_eq("b_fs_pre",     fs_b, 0);
    goto_edge(84); check_eq("b_fs_0",       fs_b, 1);
    goto_edge(85); check_eq("b_fs_post",    fs_b, 0);

    // Frame 1, fb=0110: columns two pixels wide -> bg,fg,fg,bg.
    goto_edge(eb(1, 0, 1)); check_eq("b_f1_top",  rgb_b, BORDER ? 32'd6 : 32'd0);
    goto_edge(eb(1, 1, 1)); check_eq("b_f1_x1",   rgb_b, 1);
    goto_edge(eb(1, 1, 2)); check_eq("b_f1_x2",   rgb_b, 6);
    goto_edge(eb(1, 1, 3)); check_eq("b_f1_x3",   rgb_b, 6);
    goto_edge(eb(1, 1, 4)); check_eq("b_f1_x4",   rgb_b, 6);
    goto_edge(eb(1, 1, 6)); check_eq("b_f1_x6",   rgb_b, 1);
    goto_edge(eb(1, 3, 2)); check_eq("b_f1_y3",   rgb_b, BORDER ? 32'd6 : 32'd0);
    goto_edge(168);         check_eq("b_fs_1",    fs_b, 1);

    // Reset in the middle of a lit band pixel, then restart from (0,0).
    goto_edge(eb(2, 1, 2)); check_eq("b_f2_x2", rgb_b, 6);
    reset_b = 1'b1;
    goto_edge(eb(2, 1, 2) + 1);
    check_eq("b_midrst_rgb",   rgb_b, 0);
    check_eq("b_midrst_hsync", hs_b, 1);
    goto_edge(eb(2, 1, 2) + 2);
    reset_b = 1'b0;
    edges = 0;
    goto_edge(9);           check_eq("b_rst2_hs_pre",  hs_b, 1);
    goto_edge(10);          check_eq("b_rst2_hs_fall", hs_b, 0);
    goto_edge(eb(0, 1, 2)); check_eq("b_rst2_band_bg", rgb_b, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
